fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO (w_en/data_in/full) among NUM_REQ requesters.
- Lives entirely in the write clock domain.
- Round-robin grant with bounded bursts: one owner at a time, valid/ready per requester; FIFO full back-pressures the current owner only.
- Output feeds the FIFO write side directly.

Parameters:
- DATA_WIDTH, 8, width of one write beat.
- NUM_REQ, 4, number of requesters (2..16).
- MAX_BURST, 4, max accepted beats per grant before forced release (1..255).
- CNT_WIDTH, 16, stats counter width (optional feature only).

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset: synchronous to wclk, active-low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  beat of requester i accepted this cycle when req_valid[i]&req_ready[i].
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- grant_id  out  clog2(NUM_REQ)  current/last owner index.
- busy  out  1  high in GRANT state.

Behaviour:
- States: IDLE, GRANT (registered). Registers: state, owner, last_owner, beat_cnt.
- Reset (wrst_n=0 at posedge wclk): state=IDLE, owner=0, last_owner=NUM_REQ-1, beat_cnt=0.
- Outputs after reset: req_ready=0, fifo_w_en=0, busy=0, grant_id=0.
- fifo_data_in is don't-care when fifo_w_en=0; the bench drives it to req_data of owner.
- IDLE:
  - Each cycle, search req_valid starting at last_owner+1 (wrapping modulo NUM_REQ).
  - If any hit: owner<=hit, beat_cnt<=0, state<=GRANT. Else stay.
  - No beats are accepted in IDLE. Grant latency: 1 cycle from valid sampled to ready possible.
- GRANT:
  - req_ready[owner] = !fifo_full; all other ready bits = 0 (combinational from registered owner and fifo_full).
  - fifo_w_en = req_valid[owner] & !fifo_full; fifo_data_in = req_data slice of owner.
  - Accepted beat: beat_cnt increments.
  - Release to IDLE at the edge where either:
    - (a) a beat is accepted and beat_cnt==MAX_BURST-1, or
    - (b) req_valid[owner]==0.
  - On release: last_owner<=owner, beat_cnt<=0.
  - fifo_full while granted: ready=0, no write, beat_cnt held, grant held.
  - If valid drops while full, release per (b).
- grant_id = owner. busy = (state==GRANT).
- Requesters must hold valid/data stable until accepted; the arbiter does not check this.
- Release always costs one IDLE cycle. Sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Reset mid-burst: partial burst is abandoned and no write is issued in the reset cycle. The FIFO keeps any beats already written.

Optional Feature:
- Macro FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stat_beats, NUM_REQ*CNT_WIDTH: per-requester accepted-beat counters, saturating at all-ones.
  - Adds input stat_clr, 1: synchronous clear of all counters; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: both ports and the counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum (IDLE, GRANT);
  - localparam helper for index width (clog2);
  - default DATA_WIDTH/NUM_REQ/MAX_BURST constants.
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector, start index. Outputs: hit flag and index. Instantiated once by fifo_wr_arbiter.

Test Plan:
- Reset, then req_valid=4'b0000 for 10 cycles -> fifo_w_en=0, busy=0, req_ready=0 throughout.
- Only req 2 valid with 6 beats (0xA0..0xA5), MAX_BURST=4, fifo_full=0:
  - FIFO receives A0..A3;
  - one IDLE cycle, then A4, A5;
  - grant_id=2 in both bursts.
- All four valid continuously after reset -> grant order 0,1,2,3,0.
  - Each grant gives exactly 4 writes.
  - Each grant is followed by one idle cycle.
- Req 1 granted, fifo_full forced high for 5 cycles mid-burst after beat 2:
  - no writes and ready[1]=0 while full;
  - grant held;
  - remaining 2 beats written after full drops.
- Req 3 drops valid after 1 beat while req 0 is valid -> release at that edge; next grant goes to 0 (search from 0 after last_owner=3).
- Assert wrst_n=0 during beat 2 of a burst -> next cycle fifo_w_en=0, state IDLE, last_owner=NUM_REQ-1. With FIFO_WR_ARB_STATS_EN: counters read 0.
- Scoreboard in every scenario: the FIFO read side returns per-requester data in order.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester handshake and FIFO write-side bundle
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;

  // master is the arbiter; slave is the requester/FIFO environment
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_data_in
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_data_in
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker, first hit at or after start_i
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  int unsigned cand;

  // Walk offsets from far to near so the nearest request overwrites the result last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(start_i) + k) % N;
      if (req_i[cand]) begin
        hit_o = 1'b1;
        idx_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin bounded-burst arbiter for the FIFO write port; stats under FIFO_WR_ARB_STATS_EN
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  parameter  int CNT_WIDTH  = 16,
  localparam int IW         = idx_w(NUM_REQ)
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  fifo_wr_arbiter_if.master    bus,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0] stat_beats
`endif
);

  localparam logic [7:0]    BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    beat_q, beat_d;

  logic [IW-1:0] start_idx;
  logic          pick_hit;
  logic [IW-1:0] pick_idx;
  logic          own_valid;
  logic          accept;

  assign start_idx = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .start_i (start_idx),
    .hit_o   (pick_hit),
    .idx_o   (pick_idx)
  );

  // Gating with wrst_n keeps a mid-burst reset cycle from issuing a write.
  assign own_valid = bus.req_valid[owner_q];
  assign accept    = (state_q == ST_GRANT) & own_valid & ~bus.fifo_full & wrst_n;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_IDX;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_hit) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      ST_GRANT: begin
        if ((accept && (beat_q == BURST_LAST)) || !own_valid) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          beat_d  = '0;
        end else if (accept) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_w_en    = accept;
    bus.fifo_data_in = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    if ((state_q == ST_GRANT) && wrst_n) begin
      bus.req_ready[owner_q] = ~bus.fifo_full;
    end
    grant_id = owner_q;
    busy     = (state_q == ST_GRANT);
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0] stat_q, stat_d;

  // Clear takes priority over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stat_clr) begin
        stat_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
      end else if (accept && (owner_q == IW'(i)) &&
                   (stat_q[i*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}})) begin
        stat_d[i*CNT_WIDTH +: CNT_WIDTH] = stat_q[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_beats = stat_q;
`else
  if (CNT_WIDTH < 1) begin : g_no_stats
  end
`endif

endmodule
